// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle CPU sequencer: state encodings, opcodes,
// datapath select codes and the packed control-word layout.
package multicycle_control_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OPCODE_W = 6;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'h08;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC     = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_ADDI_EX  = 4'd11,
        S_ADDI_WB  = 4'd12,
        S_TRAP     = 4'd15
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10
    } pc_src_e;

    typedef enum logic [1:0] {
        SRCB_B        = 2'b00,
        SRCB_FOUR     = 2'b01,
        SRCB_SEXT     = 2'b10,
        SRCB_SEXT_SH2 = 2'b11
    } alu_src_b_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        pc_src_e    pc_source;
        alu_op_e    alu_op;
        logic       alu_src_a;
        alu_src_b_e alu_src_b;
        logic       reg_write;
        logic       reg_dst;
        logic       illegal_op;
    } ctrl_t;

    // Loads and stores share the address-computation state.
    function automatic logic is_mem_op(input logic [OPCODE_W-1:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Sequencer <-> datapath bundle: IR opcode and memory handshake in, control pins out.
interface multicycle_control_if;
    import multicycle_control_pkg::*;

    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic                PCWrite;
    logic                PCWriteCond;
    logic                IorD;
    logic                MemRead;
    logic                MemWrite;
    logic                IRWrite;
    logic                MemtoReg;
    logic [1:0]          PCSource;
    logic [1:0]          ALUOp;
    logic                ALUSrcA;
    logic [1:0]          ALUSrcB;
    logic                RegWrite;
    logic                RegDst;
    logic                illegal_op;
    logic [STATE_W-1:0]  state_dbg;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, illegal_op, state_dbg
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
               PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, illegal_op, state_dbg
    );

endinterface

// File: rtl/multicycle_control.sv
// Moore sequencer of the multicycle CPU: decodes the IR opcode and drives every datapath
// control pin per cycle, with memory wait-states and an absorbing illegal-opcode trap.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    multicycle_control_if.master bus
);

    state_e r_state;
    state_e w_next_state;
    ctrl_t  w_ctrl;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Outputs depend on state only; FETCH additionally gates IR/PC loads with mem_ready.
    always_comb begin
        w_next_state = r_state;
        w_ctrl       = '0;
        case (r_state)
            S_IDLE: begin
                w_next_state = S_FETCH;
            end
            S_FETCH: begin
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.alu_src_b = SRCB_FOUR;
                w_ctrl.pc_source = PCSRC_ALU;
                w_ctrl.ir_write  = bus.mem_ready;
                w_ctrl.pc_write  = bus.mem_ready;
                if (bus.mem_ready) w_next_state = S_DECODE;
            end
            S_DECODE: begin
                w_ctrl.alu_src_b = SRCB_SEXT_SH2;
                if (is_mem_op(bus.opcode))       w_next_state = S_MEM_ADDR;
                else if (bus.opcode == OP_RTYPE) w_next_state = S_EXEC;
                else if (bus.opcode == OP_BEQ)   w_next_state = S_BRANCH;
                else if (bus.opcode == OP_J)     w_next_state = S_JUMP;
                else if (bus.opcode == OP_ADDI)  w_next_state = S_ADDI_EX;
                else                             w_next_state = S_TRAP;
            end
            S_MEM_ADDR: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_SEXT;
                w_ctrl.alu_op    = ALU_ADD;
                if (bus.opcode == OP_LW)      w_next_state = S_MEM_RD;
                else if (bus.opcode == OP_SW) w_next_state = S_MEM_WR;
                else                          w_next_state = S_TRAP;
            end
            S_MEM_RD: begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.iord     = 1'b1;
                if (bus.mem_ready) w_next_state = S_MEM_WB;
            end
            S_MEM_WB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_next_state      = S_FETCH;
            end
            S_MEM_WR: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.iord      = 1'b1;
                if (bus.mem_ready) w_next_state = S_FETCH;
            end
            S_EXEC: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_B;
                w_ctrl.alu_op    = ALU_FUNCT;
                w_next_state     = S_R_WB;
            end
            S_R_WB: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.reg_dst   = 1'b1;
                w_next_state     = S_FETCH;
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a     = 1'b1;
                w_ctrl.alu_src_b     = SRCB_B;
                w_ctrl.alu_op        = ALU_SUB;
                w_ctrl.pc_write_cond = 1'b1;
                w_ctrl.pc_source     = PCSRC_ALUOUT;
                w_next_state         = S_FETCH;
            end
            S_JUMP: begin
                w_ctrl.pc_write  = 1'b1;
                w_ctrl.pc_source = PCSRC_JUMP;
                w_next_state     = S_FETCH;
            end
            S_ADDI_EX: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_SEXT;
                w_ctrl.alu_op    = ALU_ADD;
                w_next_state     = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                w_ctrl.reg_write = 1'b1;
                w_next_state     = S_FETCH;
            end
            S_TRAP: begin
                w_ctrl.illegal_op = 1'b1;
                w_next_state      = S_TRAP;
            end
            default: begin
                w_next_state = S_TRAP;
            end
        endcase
    end

    assign bus.PCWrite     = w_ctrl.pc_write;
    assign bus.PCWriteCond = w_ctrl.pc_write_cond;
    assign bus.IorD        = w_ctrl.iord;
    assign bus.MemRead     = w_ctrl.mem_read;
    assign bus.MemWrite    = w_ctrl.mem_write;
    assign bus.IRWrite     = w_ctrl.ir_write;
    assign bus.MemtoReg    = w_ctrl.mem_to_reg;
    assign bus.PCSource    = w_ctrl.pc_source;
    assign bus.ALUOp       = w_ctrl.alu_op;
    assign bus.ALUSrcA     = w_ctrl.alu_src_a;
    assign bus.ALUSrcB     = w_ctrl.alu_src_b;
    assign bus.RegWrite    = w_ctrl.reg_write;
    assign bus.RegDst      = w_ctrl.reg_dst;
    assign bus.illegal_op  = w_ctrl.illegal_op;
    assign bus.state_dbg   = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: each instruction is expanded into its expected per-cycle
// control trace (with planned wait-states) and compared cycle by cycle.
module tb_multicycle_control;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    multicycle_control_if bus_if();

    multicycle_control dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        bit          mr;
        logic [20:0] exp;
    } step_t;

    step_t q[$];

    // Expected vector: {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
    // MemtoReg, PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, illegal_op}
    function automatic logic [20:0] v(input int st, input bit pcw, input bit pcwc,
                                      input bit iord, input bit mrd, input bit mwr,
                                      input bit irw, input bit m2r, input int pcs,
                                      input int aop, input bit asa, input int asb,
                                      input bit rw, input bit rd, input bit ill);
        return {4'(st), pcw, pcwc, iord, mrd, mwr, irw, m2r, 2'(pcs), 2'(aop), asa,
                2'(asb), rw, rd, ill};
    endfunction

    function automatic logic [20:0] obs();
        return {bus_if.state_dbg, bus_if.PCWrite, bus_if.PCWriteCond, bus_if.IorD,
                bus_if.MemRead, bus_if.MemWrite, bus_if.IRWrite, bus_if.MemtoReg,
                bus_if.PCSource, bus_if.ALUOp, bus_if.ALUSrcA, bus_if.ALUSrcB,
                bus_if.RegWrite, bus_if.RegDst, bus_if.illegal_op};
    endfunction

    logic [20:0] E_FETCH_WAIT, E_FETCH_GO, E_DECODE, E_MEM_ADDR, E_MEM_RD, E_MEM_WB;
    logic [20:0] E_MEM_WR, E_EXEC, E_R_WB, E_BRANCH, E_JUMP, E_ADDI_EX, E_ADDI_WB, E_TRAP;
    logic [20:0] E_ZERO;

    task automatic init_expect();
        //                 st pcw pcwc iord mrd mwr irw m2r pcs aop asa asb rw rd ill
        E_FETCH_WAIT = v( 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        E_FETCH_GO   = v( 1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        E_DECODE     = v( 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0);
        E_MEM_ADDR   = v( 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
        E_MEM_RD     = v( 4, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        E_MEM_WB     = v( 5, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
        E_MEM_WR     = v( 6, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        E_EXEC       = v( 7, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0);
        E_R_WB       = v( 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        E_BRANCH     = v( 9, 0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
        E_JUMP       = v(10, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0);
        E_ADDI_EX    = v(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0);
        E_ADDI_WB    = v(12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        E_TRAP       = v(15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        E_ZERO       = '0;
    endtask

    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(input bit mr, input logic [20:0] e);
        step_t s;
        s.mr  = mr;
        s.exp = e;
        q.push_back(s);
    endfunction

    // Expected trace of one instruction, starting in FETCH, with the planned wait-states.
    function automatic void plan_instr(input logic [5:0] op, input int fw, input int mw);
        for (int i = 0; i < fw; i++) push(1'b0, E_FETCH_WAIT);
        push(1'b1, E_FETCH_GO);
        push(rb(), E_DECODE);
        case (op)
            6'h23: begin
                push(rb(), E_MEM_ADDR);
                for (int i = 0; i < mw; i++) push(1'b0, E_MEM_RD);
                push(1'b1, E_MEM_RD);
                push(rb(), E_MEM_WB);
            end
            6'h2B: begin
                push(rb(), E_MEM_ADDR);
                for (int i = 0; i < mw; i++) push(1'b0, E_MEM_WR);
                push(1'b1, E_MEM_WR);
            end
            6'h00: begin
                push(rb(), E_EXEC);
                push(rb(), E_R_WB);
            end
            6'h04: push(rb(), E_BRANCH);
            6'h02: push(rb(), E_JUMP);
            6'h08: begin
                push(rb(), E_ADDI_EX);
                push(rb(), E_ADDI_WB);
            end
            default: for (int i = 0; i < 12; i++) push(rb(), E_TRAP);
        endcase
    endfunction

    task automatic test_reset();
        bus_if.mem_ready = 1'b1;
        bus_if.opcode    = 6'h23;
        reset_n          = 1'b0;
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (obs() !== E_ZERO) $display("FAIL reset_hold got %h want %h", obs(), E_ZERO);
            else n_pass++;
        end
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (obs() !== E_ZERO) $display("FAIL reset_idle got %h want %h", obs(), E_ZERO);
        else n_pass++;
        bus_if.mem_ready = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (obs() !== E_FETCH_WAIT) $display("FAIL reset_fetch got %h want %h", obs(), E_FETCH_WAIT);
        else n_pass++;
    endtask

    task automatic test_lw();
        bus_if.opcode = 6'h23;
        plan_instr(6'h23, 0, 0);
        push(1'b0, E_FETCH_WAIT);
        while (q.size() > 0) begin
            step_t s;
            s = q.pop_front();
            bus_if.mem_ready = s.mr;
            @(negedge clk);
            n_checks++;
            if (obs() !== s.exp) $display("FAIL lw got %h want %h", obs(), s.exp);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_wait();
        int mw_cycles;
        mw_cycles = 0;
        bus_if.opcode = 6'h2B;
        plan_instr(6'h2B, 0, 3);
        while (q.size() > 0) begin
            step_t s;
            s = q.pop_front();
            bus_if.mem_ready = s.mr;
            @(negedge clk);
            if (bus_if.MemWrite === 1'b1) mw_cycles++;
            n_checks++;
            if (obs() !== s.exp) $display("FAIL sw_wait got %h want %h", obs(), s.exp);
            else n_pass++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (mw_cycles != 4) $display("FAIL sw_memwrite_len got %0d want 4", mw_cycles);
        else n_pass++;
    endtask

    task automatic test_fetch_wait();
        bus_if.opcode = 6'h00;
        plan_instr(6'h00, 2, 0);
        while (q.size() > 0) begin
            step_t s;
            s = q.pop_front();
            bus_if.mem_ready = s.mr;
            @(negedge clk);
            n_checks++;
            if (obs() !== s.exp) $display("FAIL fetch_wait got %h want %h", obs(), s.exp);
            else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_jump();
        logic [5:0] ops [3];
        ops[0] = 6'h04;
        ops[1] = 6'h02;
        ops[2] = 6'h08;
        for (int k = 0; k < 3; k++) begin
            bus_if.opcode = ops[k];
            plan_instr(ops[k], 0, 0);
            while (q.size() > 0) begin
                step_t s;
                s = q.pop_front();
                bus_if.mem_ready = s.mr;
                @(negedge clk);
                n_checks++;
                if (obs() !== s.exp) $display("FAIL branch_jump op=%h got %h want %h", ops[k], obs(), s.exp);
                else n_pass++;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [6];
        ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B;
        ops[3] = 6'h04; ops[4] = 6'h02; ops[5] = 6'h08;
        for (int k = 0; k < 30; k++) begin
            logic [5:0] op;
            op = ops[$urandom_range(0, 5)];
            bus_if.opcode = op;
            plan_instr(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            while (q.size() > 0) begin
                step_t s;
                s = q.pop_front();
                bus_if.mem_ready = s.mr;
                @(negedge clk);
                n_checks++;
                if (obs() !== s.exp) $display("FAIL random op=%h got %h want %h", op, obs(), s.exp);
                else n_pass++;
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset_midop();
        bus_if.opcode = 6'h23;
        push(1'b1, E_FETCH_GO);
        push(1'b1, E_DECODE);
        push(1'b1, E_MEM_ADDR);
        push(1'b0, E_MEM_RD);
        while (q.size() > 0) begin
            step_t s;
            s = q.pop_front();
            bus_if.mem_ready = s.mr;
            @(negedge clk);
            n_checks++;
            if (obs() !== s.exp) $display("FAIL midop_lead got %h want %h", obs(), s.exp);
            else n_pass++;
            @(posedge clk); #1;
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (obs() !== E_ZERO) $display("FAIL midop_async got %h want %h", obs(), E_ZERO);
        else n_pass++;
        bus_if.mem_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (obs() !== E_ZERO) $display("FAIL midop_held got %h want %h", obs(), E_ZERO);
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        bus_if.mem_ready = 1'b0;
        #1;
        n_checks++;
        if (obs() !== E_ZERO) $display("FAIL midop_idle got %h want %h", obs(), E_ZERO);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (obs() !== E_FETCH_WAIT) $display("FAIL midop_fetch got %h want %h", obs(), E_FETCH_WAIT);
        else n_pass++;
    endtask

    task automatic test_trap();
        bus_if.opcode = 6'h3F;
        plan_instr(6'h3F, int'($urandom_range(0, 2)), 0);
        while (q.size() > 0) begin
            step_t s;
            s = q.pop_front();
            bus_if.mem_ready = s.mr;
            @(negedge clk);
            n_checks++;
            if (obs() !== s.exp) $display("FAIL trap got %h want %h", obs(), s.exp);
            else n_pass++;
            @(posedge clk); #1;
        end
        bus_if.opcode = 6'h00;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (obs() !== E_ZERO) $display("FAIL trap_clear got %h want %h", obs(), E_ZERO);
        else n_pass++;
        @(negedge clk);
        reset_n = 1'b1;
        bus_if.mem_ready = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (obs() !== E_FETCH_WAIT) $display("FAIL trap_restart got %h want %h", obs(), E_FETCH_WAIT);
        else n_pass++;
    endtask

    initial begin
        init_expect();
        test_reset();
        test_lw();
        test_sw_wait();
        test_fetch_wait();
        test_branch_jump();
        test_random();
        test_reset_midop();
        test_trap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
